// File: rtl/stack_pkg.sv
// stack_pkg
// Shared definitions for the operand stack: default geometry and the
// internal command encoding produced by the stack_unit priority decoder.
package stack_pkg;

  localparam int unsigned STACK_WIDTH_DEF = 8;
  localparam int unsigned STACK_DEPTH_DEF = 16;

  // Resolved per-cycle command after priority and empty/full guards.
  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_PUSH = 3'd1,
    CMD_POP  = 3'd2,
    CMD_TOP  = 3'd3,
    CMD_REPL = 3'd4
  } cmd_e;

endpackage

// File: rtl/stack_ram.sv
// stack_ram
// DEPTH x WIDTH storage for the operand stack. One synchronous write port,
// one asynchronous read port. Contents are not reset.
// Ports:
//   clk     - write clock
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address (combinational read)
//   rdata_o - read data
module stack_ram
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = STACK_WIDTH_DEF,
  parameter int unsigned DEPTH = STACK_DEPTH_DEF,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/stack_unit.sv
// stack_unit
// Hardware operand stack for the multicycle stack-machine datapath.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-low reset
//   push    - push din
//   pop     - pop top entry; value on dout next cycle
//   top     - copy top entry to dout without removing it
//   din     - data to push
//   clr_err - synchronous clear of ovf/unf (an error event in the same cycle wins)
//   dout    - registered top-of-stack read result
//   count   - number of entries, 0..DEPTH
//   empty   - count == 0
//   full    - count == DEPTH
//   ovf     - sticky: push attempted while full
//   unf     - sticky: pop or top attempted while empty
module stack_unit
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = STACK_WIDTH_DEF,
  parameter int unsigned DEPTH = STACK_DEPTH_DEF,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             top,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam logic [PTR_W:0] SP_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] SP_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W:0]   sp_q, sp_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [PTR_W:0]   sp_m1;
  logic             is_empty, is_full;
  cmd_e             cmd;
  logic             ovf_ev, unf_ev;

  logic             ram_we;
  logic [PTR_W-1:0] ram_waddr;
  logic [WIDTH-1:0] ram_rdata;

  assign sp_m1    = sp_q - SP_ONE;
  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == SP_FULL);

  // Priority decoder: push&pop > pop > push > top, with empty/full guards
  // turning illegal requests into error events instead of state changes.
  always_comb begin
    cmd    = CMD_NONE;
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    if (push && pop) begin
      if (!is_empty) begin
        cmd = CMD_REPL;
      end else begin
        // Empty stack can never be full (DEPTH >= 2), so the push proceeds.
        cmd    = CMD_PUSH;
        unf_ev = 1'b1;
      end
    end else if (pop) begin
      if (!is_empty) begin
        cmd = CMD_POP;
      end else begin
        unf_ev = 1'b1;
      end
    end else if (push) begin
      if (!is_full) begin
        cmd = CMD_PUSH;
      end else begin
        ovf_ev = 1'b1;
      end
    end else if (top) begin
      if (!is_empty) begin
        cmd = CMD_TOP;
      end else begin
        unf_ev = 1'b1;
      end
    end
  end

  always_comb begin
    sp_d      = sp_q;
    dout_d    = dout_q;
    ram_we    = 1'b0;
    ram_waddr = sp_q[PTR_W-1:0];
    unique case (cmd)
      CMD_PUSH: begin
        ram_we = 1'b1;
        sp_d   = sp_q + SP_ONE;
      end
      CMD_POP: begin
        dout_d = ram_rdata;
        sp_d   = sp_m1;
      end
      CMD_TOP: begin
        dout_d = ram_rdata;
      end
      CMD_REPL: begin
        // Old top is captured from the async read while the new word
        // overwrites the same slot at this edge.
        dout_d    = ram_rdata;
        ram_we    = 1'b1;
        ram_waddr = sp_m1[PTR_W-1:0];
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    ovf_d = ovf_ev | (ovf_q & ~clr_err);
    unf_d = unf_ev | (unf_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q   <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (din),
    .raddr_i (sp_m1[PTR_W-1:0]),
    .rdata_o (ram_rdata)
  );

  assign dout  = dout_q;
  assign count = sp_q;
  assign empty = is_empty;
  assign full  = is_full;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
module tb_stack_unit;

  logic       clk;
  logic       rst;
  logic       push, pop, top, clr_err;
  logic [7:0] din;
  logic [7:0] dout;
  logic [4:0] count;
  logic       empty, full, ovf, unf;

  int total = 0;
  int bad   = 0;

  stack_unit #(
    .WIDTH (8),
    .DEPTH (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .top     (top),
    .din     (din),
    .clr_err (clr_err),
    .dout    (dout),
    .count   (count),
    .empty   (empty),
    .full    (full),
    .ovf     (ovf),
    .unf     (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of strobes, let the edge happen, sample #1 later.
  task automatic cyc(input logic pu, input logic po, input logic tp,
                     input logic ce, input logic [7:0] d);
    push = pu; pop = po; top = tp; clr_err = ce; din = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; top = 1'b0; clr_err = 1'b0; din = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    push = 0; pop = 0; top = 0; clr_err = 0; din = 0;
    rst = 1'b0;
    #12;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
    total++; if ({empty, full, ovf, unf} !== 4'b1000) begin bad++; $display("FAIL reset_flags got=%b exp=1000", {empty, full, ovf, unf}); end
    rst = 1'b1;
    #1;
  endtask

  task automatic test_lifo();
    do_reset();
    cyc(1, 0, 0, 0, 8'h11);
    cyc(1, 0, 0, 0, 8'h22);
    cyc(1, 0, 0, 0, 8'h33);
    total++; if (count !== 5'd3) begin bad++; $display("FAIL lifo_count3 got=%0d exp=3", count); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL lifo_push_no_dout got=%h exp=00", dout); end
    cyc(0, 0, 1, 0, 8'h00);
    total++; if (dout !== 8'h33 || count !== 5'd3) begin bad++; $display("FAIL lifo_top got=%h/%0d exp=33/3", dout, count); end
    cyc(0, 0, 0, 0, 8'h00);
    total++; if (dout !== 8'h33 || count !== 5'd3) begin bad++; $display("FAIL lifo_hold got=%h/%0d exp=33/3", dout, count); end
    cyc(0, 1, 0, 0, 8'h00);
    total++; if (dout !== 8'h33 || count !== 5'd2) begin bad++; $display("FAIL lifo_pop1 got=%h/%0d exp=33/2", dout, count); end
    cyc(0, 1, 1, 0, 8'h00);
    total++; if (dout !== 8'h22 || count !== 5'd1) begin bad++; $display("FAIL lifo_pop2 got=%h/%0d exp=22/1", dout, count); end
    cyc(0, 1, 0, 0, 8'h00);
    total++; if (dout !== 8'h11 || count !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL lifo_pop3 got=%h/%0d/%b exp=11/0/1", dout, count, empty); end
    total++; if (unf !== 1'b0) begin bad++; $display("FAIL lifo_no_unf got=%b exp=0", unf); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 8'(i));
    total++; if (full !== 1'b1 || count !== 5'd16 || ovf !== 1'b0) begin bad++; $display("FAIL full_set got=%b/%0d/%b exp=1/16/0", full, count, ovf); end
    cyc(1, 0, 0, 0, 8'hFF);
    total++; if (ovf !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL full_ovf got=%b/%0d exp=1/16", ovf, count); end
    cyc(0, 0, 1, 0, 8'h00);
    total++; if (dout !== 8'h0F) begin bad++; $display("FAIL full_top got=%h exp=0F", dout); end
    // Error event in the same cycle as clr_err wins.
    cyc(1, 0, 0, 1, 8'hEE);
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL full_clr_vs_ovf got=%b exp=1", ovf); end
    cyc(0, 0, 0, 1, 8'h00);
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL full_clr got=%b exp=0", ovf); end
  endtask

  task automatic test_underflow();
    do_reset();
    cyc(0, 1, 0, 0, 8'h00);
    total++; if (unf !== 1'b1 || dout !== 8'h00 || count !== 5'd0) begin bad++; $display("FAIL unf_pop got=%b/%h/%0d exp=1/00/0", unf, dout, count); end
    cyc(0, 0, 0, 1, 8'h00);
    total++; if (unf !== 1'b0) begin bad++; $display("FAIL unf_clr got=%b exp=0", unf); end
    cyc(0, 0, 1, 1, 8'h00);
    total++; if (unf !== 1'b1) begin bad++; $display("FAIL unf_clr_top got=%b exp=1", unf); end
    cyc(0, 0, 0, 1, 8'h00);
    // push&pop on empty: push only, unf set.
    cyc(1, 1, 0, 0, 8'h44);
    total++; if (unf !== 1'b1 || count !== 5'd1 || dout !== 8'h00) begin bad++; $display("FAIL unf_pushpop_empty got=%b/%0d/%h exp=1/1/00", unf, count, dout); end
    cyc(0, 0, 1, 0, 8'h00);
    total++; if (dout !== 8'h44) begin bad++; $display("FAIL unf_pushpop_top got=%h exp=44", dout); end
  endtask

  task automatic test_replace();
    do_reset();
    cyc(1, 0, 0, 0, 8'h05);
    cyc(1, 0, 0, 0, 8'h09);
    cyc(1, 1, 0, 0, 8'h7A);
    total++; if (dout !== 8'h09 || count !== 5'd2) begin bad++; $display("FAIL repl_old got=%h/%0d exp=09/2", dout, count); end
    cyc(0, 0, 1, 0, 8'h00);
    total++; if (dout !== 8'h7A) begin bad++; $display("FAIL repl_top got=%h exp=7A", dout); end
    cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    total++; if (dout !== 8'h05 || empty !== 1'b1) begin bad++; $display("FAIL repl_below got=%h/%b exp=05/1", dout, empty); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1, 0, 0, 0, 8'hAA);
    cyc(1, 0, 0, 0, 8'hBB);
    cyc(0, 0, 1, 0, 8'h00);
    total++; if (dout !== 8'hBB || count !== 5'd2) begin bad++; $display("FAIL arst_pre got=%h/%0d exp=BB/2", dout, count); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (count !== 5'd0 || dout !== 8'h00 || empty !== 1'b1) begin bad++; $display("FAIL arst_now got=%0d/%h/%b exp=0/00/1", count, dout, empty); end
    #1;
    rst = 1'b1;
    cyc(1, 0, 0, 0, 8'hCC);
    cyc(0, 0, 1, 0, 8'h00);
    total++; if (dout !== 8'hCC || count !== 5'd1) begin bad++; $display("FAIL arst_after got=%h/%0d exp=CC/1", dout, count); end
  endtask

  task automatic test_full_replace();
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 8'(i));
    cyc(1, 1, 0, 0, 8'h3C);
    total++; if (ovf !== 1'b0 || count !== 5'd16 || dout !== 8'h0F) begin bad++; $display("FAIL frepl got=%b/%0d/%h exp=0/16/0F", ovf, count, dout); end
    cyc(0, 0, 1, 0, 8'h00);
    total++; if (dout !== 8'h3C) begin bad++; $display("FAIL frepl_top got=%h exp=3C", dout); end
    cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    total++; if (dout !== 8'h0E || count !== 5'd14) begin bad++; $display("FAIL frepl_below got=%h/%0d exp=0E/14", dout, count); end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_full();
    test_underflow();
    test_replace();
    test_async_reset();
    test_full_replace();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware operand stack for the multicycle stack-machine datapath. It receives the controller's `push` / `pop` / `top` strobes through the datapath and stores ALU results and memory operands. It returns the top-of-stack word through a registered output that the datapath feeds back into the A register or the memory data path. It also reports occupancy and sticky overflow/underflow errors for debug and for halting the controller.

## Interface
Parameters:
- `WIDTH`, 8, data word width (matches datapath word)
- `DEPTH`, 16, number of stack entries; power of two, ≥ 2
- `PTR_W`, $clog2(DEPTH), stack-pointer width

Ports:
- `clk` input 1 — single clock; all state updates on the rising edge
- `rst` input 1 — asynchronous, active-low reset
- `push` input 1 — write `din` onto the stack this cycle
- `pop` input 1 — remove the top entry; its value appears on `dout` next cycle
- `top` input 1 — copy the top entry to `dout` without removing it
- `din` input WIDTH — data to push
- `clr_err` input 1 — synchronous clear of `ovf` / `unf`
- `dout` output WIDTH — registered top-of-stack read result
- `count` output PTR_W+1 — current number of entries, 0..DEPTH
- `empty` output 1 — `count == 0` (combinational from `count`)
- `full` output 1 — `count == DEPTH` (combinational from `count`)
- `ovf` output 1 — sticky: a push was attempted while full
- `unf` output 1 — sticky: a pop or top was attempted while empty

## Operation
- Storage: DEPTH × WIDTH array plus pointer `sp` (PTR_W+1 bits) equal to `count`. The top entry is `mem[sp-1]`. Array contents are not reset.
- Per-cycle command decode, evaluated against pre-edge state; priority top-down:
  - `push & pop`, not empty: replace. `dout <= mem[sp-1]`, then `mem[sp-1] <= din`; `sp` unchanged. If full this is still legal, and `ovf` is not set.
  - `push & pop`, empty: treated as a push only, and `unf` is set.
  - `pop`, not empty: `dout <= mem[sp-1]`, `sp <= sp-1`.
  - `pop`, empty: `sp`, `dout` and the array are unchanged; `unf <= 1`.
  - `push`, not full: `mem[sp] <= din`, `sp <= sp+1`; `dout` unchanged.
  - `push`, full: ignored; `ovf <= 1`.
  - `top` (no push/pop), not empty: `dout <= mem[sp-1]`.
  - `top`, empty: `dout` unchanged; `unf <= 1`.
  - `top` combined with `pop` is treated as `pop`. `top` combined with `push` ignores `top`.
  - No strobe: hold all state.
- `clr_err` clears `ovf` and `unf`. If an error event occurs in the same cycle, the event wins and the flag is set.
- `sp` never wraps. It saturates at 0 and at DEPTH through the guards above.

## Timing
- Reset (`rst` low, asynchronous): `sp=0`, `dout=0`, `ovf=0`, `unf=0`. Therefore `count=0`, `empty=1`, `full=0`.
- Reset assertion mid-operation aborts any in-flight command immediately. The array may hold stale data, but it is unreachable because `sp=0`.
- Deassertion is synchronous to the controller's reset release; no internal synchronizer.
- Read latency: 1 cycle. A value selected by `pop` or `top` at edge N is on `dout` after edge N and holds until the next successful `pop`, `top` or replace.
- Write latency: 1 cycle. A pushed word is readable by a `top` or `pop` issued in the next cycle. There is no same-cycle bypass except the replace case, which returns the old top.
- `count`, `empty` and `full` reflect the post-edge `sp`.
- No handshake back-pressure. The controller must consult `full`/`empty`; violations are absorbed and flagged, never corrupt state.

## Structure
- Shared package `stack_pkg`: default `WIDTH`/`DEPTH` constants and a command enum {`CMD_NONE`, `CMD_PUSH`, `CMD_POP`, `CMD_TOP`, `CMD_REPL`} produced by the internal priority decoder.
- Sub-module `stack_ram`: DEPTH × WIDTH, one synchronous write port, one asynchronous read port addressed by `sp-1`. It has no reset.
- `stack_unit` holds `sp`, `dout`, the flags and the decoder.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 → `count=3`. Then `top` → `dout=0x33`, `count=3`. Then three pops → `dout` shows 0x33, 0x22, 0x11 on successive cycles, then `empty=1`.
- Fill with DEPTH=16 pushes of 0x00..0x0F → `full=1`. 17th push of 0xFF → `ovf=1`, `count=16`. Then `top` → `dout=0x0F`.
- From reset, `pop` → `unf=1`, `dout=0x00`, `count=0`. Then `clr_err` → `unf=0`. Then `clr_err` together with `top` → `unf` stays 1.
- Stack [0x05, 0x09] (0x09 on top), then `push & pop` with `din=0x7A` → `dout=0x09`, `count=2`. Then `top` → `dout=0x7A`.
- Push 0xAA, 0xBB, then assert `rst` low between edges → `count=0`, `dout=0`, `empty=1` immediately. After release, push 0xCC and `top` → `dout=0xCC`.
- Full stack, `push & pop` with `din=0x3C` → `ovf=0`, `count=16`, `dout` = old top. Then `top` → `dout=0x3C`.
